// File: rtl/click_classifier_if.sv
// Press-in / click-event-out bundle for click_classifier; evt_total exists only with CLICK_STATS_EN.
// slave = classifier side, master = button stage plus control logic side.
interface click_classifier_if #(
    parameter int CNT_W = 2
);
    logic             press;
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_count;
    logic             drop;
`ifdef CLICK_STATS_EN
    logic [15:0]      evt_total;
`endif

    modport slave (
        input  press,
        input  evt_ready,
        output evt_valid,
        output evt_count,
        output drop
`ifdef CLICK_STATS_EN
        ,
        output evt_total
`endif
    );

    modport master (
        output press,
        output evt_ready,
        input  evt_valid,
        input  evt_count,
        input  drop
`ifdef CLICK_STATS_EN
        ,
        input  evt_total
`endif
    );
endinterface

// File: rtl/click_classifier.sv
// Groups press pulses into bursts and emits one click-count event per burst; CLICK_STATS_EN adds evt_total.
// Latency: event WINDOW cycles after the last press, or the next cycle when the MAX_CLICKS-th press lands.
// Backpressure: event held until evt_ready; presses arriving while it waits are discarded with a drop pulse.
module click_classifier #(
    parameter int WINDOW     = 1000,
    parameter int MAX_CLICKS = 3,
    parameter int CNT_W      = 2,
    parameter int TMR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    click_classifier_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W:0]   LP_MAX_EXT = (CNT_W+1)'(MAX_CLICKS);
    localparam logic [CNT_W-1:0] LP_MAX_CNT = CNT_W'(MAX_CLICKS);
    localparam logic [TMR_W-1:0] LP_TMO     = TMR_W'(WINDOW - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_clicks;
    logic [TMR_W-1:0] r_timer;
    logic             r_evt_valid;
    logic [CNT_W-1:0] r_evt_count;
    logic             r_drop;

    logic [CNT_W:0]   w_clicks_inc;
    logic             w_close_max;
    logic             w_timeout;
    logic             w_accept;

    // Compare one bit wider so clicks+1 cannot alias when MAX_CLICKS fills CNT_W.
    assign w_clicks_inc = {1'b0, r_clicks} + (CNT_W+1)'(1);
    assign w_close_max  = (w_clicks_inc == LP_MAX_EXT);
    assign w_timeout    = (r_timer == LP_TMO);
    assign w_accept     = (r_state == ST_HOLD) && r_evt_valid && bus.evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_clicks    <= '0;
            r_timer     <= '0;
            r_evt_valid <= 1'b0;
            r_evt_count <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.press) begin
                        r_state  <= ST_COUNT;
                        r_clicks <= CNT_W'(1);
                        r_timer  <= '0;
                    end
                end
                ST_COUNT: begin
                    // A press on the timeout cycle is counted rather than closing the burst.
                    if (bus.press) begin
                        if (w_close_max) begin
                            r_state     <= ST_HOLD;
                            r_evt_valid <= 1'b1;
                            r_evt_count <= LP_MAX_CNT;
                        end else begin
                            r_clicks <= w_clicks_inc[CNT_W-1:0];
                            r_timer  <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_HOLD;
                        r_evt_valid <= 1'b1;
                        r_evt_count <= r_clicks;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_accept) begin
                        r_evt_valid <= 1'b0;
                        if (bus.press) begin
                            r_state  <= ST_COUNT;
                            r_clicks <= CNT_W'(1);
                            r_timer  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.press) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_evt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.evt_valid = r_evt_valid;
    assign bus.evt_count = r_evt_count;
    assign bus.drop      = r_drop;

`ifdef CLICK_STATS_EN
    logic [15:0] r_evt_total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_total <= '0;
        end else if (w_accept) begin
            r_evt_total <= r_evt_total + 16'd1;
        end
    end

    assign bus.evt_total = r_evt_total;
`endif
endmodule
